// File: rtl/spi_flash_arbiter.sv
// Arbitrates the board SPI flash between the FT2232 programming port (raw pass-through)
// and a single-byte read engine for the 6809, and sequences the CPU HALT/RESET handshake.
module spi_flash_arbiter #(
  parameter int CLK_DIV     = 2,
  parameter int HALT_SETTLE = 8,
  parameter int RESET_HOLD  = 16,
  parameter int CS_GAP      = 2
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_FT_CS,
  input  logic        i_FT_SCK,
  input  logic        i_FT_MOSI,
  output logic        o_FT_MISO,
  input  logic        i_CPU_REQ,
  input  logic [23:0] i_CPU_ADDR,
  output logic        o_CPU_BUSY,
  output logic        o_CPU_VALID,
  output logic [7:0]  o_CPU_DATA,
  input  logic        i_SPI_MISO,
  output logic        o_SPI_CLK,
  output logic        o_SPI_MOSI,
  output logic        o_SPI_CS,
  output logic        o_HALT,
  output logic        o_RESET
);

  typedef enum logic [2:0] {
    IDLE,
    ENG_SHIFT,
    ENG_GAP,
    FT_HALT,
    FT_PASS,
    FT_RELEASE
  } state_t;

  localparam logic [7:0]  READ_CMD   = 8'h03;
  localparam logic [5:0]  LAST_BIT   = 6'd39;
  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST   = 16'(CS_GAP - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(HALT_SETTLE - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(RESET_HOLD - 1);

  state_t      state;
  logic        cs_sync_p0;
  logic        cs_sync_p1;
  logic        ft_req;
  logic        pass;
  logic        cs_q;
  logic        sck_q;
  logic        mosi_q;
  logic [39:0] shreg;
  logic [5:0]  bit_cnt;
  logic [15:0] div_cnt;
  logic [15:0] cnt;

  assign ft_req = ~cs_sync_p1;
  assign pass   = (state == FT_PASS);

  // Pass-through is purely combinational so the FT2232 sees no extra latency on the bus.
  assign o_SPI_CLK  = pass ? i_FT_SCK  : sck_q;
  assign o_SPI_MOSI = pass ? i_FT_MOSI : mosi_q;
  assign o_SPI_CS   = pass ? i_FT_CS   : cs_q;
  assign o_FT_MISO  = pass ? i_SPI_MISO : 1'bz;

  // Read-engine shift register: command/address out, read byte in. Pure datapath, no reset.
  always_ff @(posedge i_CLK) begin
    if (state == IDLE && !ft_req && i_CPU_REQ) begin
      shreg <= {READ_CMD, i_CPU_ADDR, 8'h00};
    end else if (state == ENG_SHIFT && div_cnt == DIV_LAST && !sck_q) begin
      shreg <= {shreg[38:0], i_SPI_MISO};
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state       <= IDLE;
      cs_sync_p0  <= 1'b1;
      cs_sync_p1  <= 1'b1;
      cs_q        <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      o_HALT      <= 1'b0;
      o_RESET     <= 1'b0;
      o_CPU_BUSY  <= 1'b0;
      o_CPU_VALID <= 1'b0;
      o_CPU_DATA  <= 8'h00;
      bit_cnt     <= '0;
      div_cnt     <= '0;
      cnt         <= '0;
    end else begin
      cs_sync_p0  <= i_FT_CS;
      cs_sync_p1  <= cs_sync_p0;
      o_CPU_VALID <= 1'b0;
      case (state)
        IDLE: begin
          cs_q    <= 1'b1;
          sck_q   <= 1'b0;
          mosi_q  <= 1'b0;
          bit_cnt <= '0;
          div_cnt <= '0;
          cnt     <= '0;
          if (ft_req) begin
            state   <= FT_HALT;
            o_HALT  <= 1'b1;
            o_RESET <= 1'b1;
          end else if (i_CPU_REQ) begin
            state      <= ENG_SHIFT;
            o_CPU_BUSY <= 1'b1;
            cs_q       <= 1'b0;
            mosi_q     <= READ_CMD[7];
          end
        end

        // Mode 0: MOSI changes entering the low phase, MISO captured on the rising edge.
        ENG_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!sck_q) begin
              sck_q <= 1'b1;
            end else if (bit_cnt == LAST_BIT) begin
              sck_q       <= 1'b0;
              cs_q        <= 1'b1;
              mosi_q      <= 1'b0;
              o_CPU_VALID <= 1'b1;
              o_CPU_BUSY  <= 1'b0;
              o_CPU_DATA  <= shreg[7:0];
              cnt         <= '0;
              state       <= ENG_GAP;
            end else begin
              sck_q   <= 1'b0;
              mosi_q  <= shreg[39];
              bit_cnt <= bit_cnt + 6'd1;
            end
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end

        ENG_GAP: begin
          if (cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        FT_HALT: begin
          cs_q  <= 1'b1;
          sck_q <= 1'b0;
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= ft_req ? FT_PASS : FT_RELEASE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        FT_PASS: begin
          if (!ft_req) begin
            cnt   <= '0;
            state <= FT_RELEASE;
          end
        end

        // CPU stays in reset for the hold window; a fresh CS assertion waits for IDLE.
        FT_RELEASE: begin
          cs_q  <= 1'b1;
          sck_q <= 1'b0;
          if (cnt == HOLD_LAST) begin
            o_HALT  <= 1'b0;
            o_RESET <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed bench for spi_flash_arbiter: engine reads against a small flash model,
// FT2232 sessions, arbitration boundaries and mid-read reset.
module tb_spi_flash_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ft_cs = 1'b1;
  logic        ft_sck = 1'b0;
  logic        ft_mosi = 1'b0;
  wire         ft_miso;
  logic        cpu_req = 1'b0;
  logic [23:0] cpu_addr = 24'h0;
  logic        busy;
  logic        valid;
  logic [7:0]  data;
  wire         spi_miso;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_cs;
  logic        halt;
  logic        cpu_rst;

  logic        model_miso = 1'b0;
  logic        tb_miso = 1'b0;
  logic        use_tb_miso = 1'b0;
  logic [7:0]  flash_byte = 8'h00;
  logic [39:0] cap = '0;
  int          bitn = 0;
  int          cs_falls = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n;
  int          base;
  logic        seen;

  assign spi_miso = use_tb_miso ? tb_miso : model_miso;

  spi_flash_arbiter dut (
    .i_CLK       (clk),
    .i_RST       (rst),
    .i_FT_CS     (ft_cs),
    .i_FT_SCK    (ft_sck),
    .i_FT_MOSI   (ft_mosi),
    .o_FT_MISO   (ft_miso),
    .i_CPU_REQ   (cpu_req),
    .i_CPU_ADDR  (cpu_addr),
    .o_CPU_BUSY  (busy),
    .o_CPU_VALID (valid),
    .o_CPU_DATA  (data),
    .i_SPI_MISO  (spi_miso),
    .o_SPI_CLK   (spi_clk),
    .o_SPI_MOSI  (spi_mosi),
    .o_SPI_CS    (spi_cs),
    .o_HALT      (halt),
    .o_RESET     (cpu_rst)
  );

  always #5 clk = ~clk;

  // Flash model: capture MOSI on SCK rise, present the read byte on SCK falls after bit 31.
  always @(negedge spi_cs or posedge spi_clk) begin
    if (spi_clk) begin
      if (spi_cs === 1'b0) begin
        cap  = {cap[38:0], spi_mosi};
        bitn = bitn + 1;
      end
    end else begin
      bitn = 0;
      cap  = '0;
    end
  end

  always @(negedge spi_clk) begin
    if (spi_cs === 1'b0 && bitn >= 32 && bitn < 40) model_miso = flash_byte[39 - bitn];
  end

  always @(negedge spi_cs) cs_falls = cs_falls + 1;

  task automatic tick(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int limit, output int edges);
    edges = 0;
    for (int i = 0; i < limit; i++) begin
      tick(1);
      edges++;
      if (valid === 1'b1) break;
    end
  endtask

  initial begin
    // Reset state
    use_tb_miso = 1'b1;
    tb_miso     = 1'b1;
    tick(2);
    check("rst_cs", spi_cs, 1);
    check("rst_sck", spi_clk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_halt", halt, 0);
    check("rst_reset", cpu_rst, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_ft_miso_undriven", (ft_miso === 1'b1), 0);
    rst         = 1'b0;
    use_tb_miso = 1'b0;
    tick(1);

    // Basic engine read: 0x012345 -> 0xA5, 161 cycles counting the accept cycle
    flash_byte = 8'hA5;
    cpu_addr   = 24'h012345;
    cpu_req    = 1'b1;
    tick(1);
    check("rd1_busy", busy, 1);
    check("rd1_cs_low", spi_cs, 0);
    cpu_addr = 24'hFFFFFF;
    wait_valid(400, n);
    cpu_req = 1'b0;
    check("rd1_latency", 1 + n, 161);
    check("rd1_data", data, 8'hA5);
    check("rd1_busy_drop", busy, 0);
    check("rd1_cs_high", spi_cs, 1);
    check("rd1_mosi_stream", cap[39:8], 32'h03012345);
    tick(1);
    check("rd1_valid_pulse", valid, 0);
    check("rd1_gap1", spi_cs, 1);
    tick(1);
    check("rd1_gap2", spi_cs, 1);
    tick(3);

    // FT session from IDLE
    ft_cs = 1'b0;
    tick(2);
    check("ft_halt_not_yet", halt, 0);
    tick(1);
    check("ft_halt_rise", halt, 1);
    check("ft_reset_rise", cpu_rst, 1);
    check("ft_settle_cs", spi_cs, 1);
    tick(8);
    ft_sck      = 1'b1;
    ft_mosi     = 1'b1;
    use_tb_miso = 1'b1;
    tb_miso     = 1'b1;
    #1;
    check("pass_sck", spi_clk, 1);
    check("pass_mosi", spi_mosi, 1);
    check("pass_cs", spi_cs, 0);
    check("pass_miso1", ft_miso, 1);
    tb_miso = 1'b0;
    ft_sck  = 1'b0;
    #1;
    check("pass_miso0", ft_miso, 0);
    check("pass_sck0", spi_clk, 0);
    tb_miso = 1'b1;
    ft_mosi = 1'b0;
    tick(1);
    ft_cs = 1'b1;
    tick(3);
    check("rel_cs", spi_cs, 1);
    check("rel_ft_miso_undriven", (ft_miso === 1'b1), 0);
    tick(15);
    check("rel_halt_held", halt, 1);
    check("rel_reset_held", cpu_rst, 1);
    tick(1);
    check("rel_halt_drop", halt, 0);
    check("rel_reset_drop", cpu_rst, 0);
    use_tb_miso = 1'b0;
    tick(2);

    // FT request 50 cycles into a CPU read does not abort it
    flash_byte = 8'h3C;
    cpu_addr   = 24'hABCDEF;
    cpu_req    = 1'b1;
    tick(50);
    ft_cs = 1'b0;
    wait_valid(400, n);
    cpu_req = 1'b0;
    check("arb_latency", 50 + n, 161);
    check("arb_data", data, 8'h3C);
    check("arb_mosi_stream", cap[39:8], 32'h03ABCDEF);
    check("arb_halt_during_read", halt, 0);
    tick(2);
    check("arb_halt_during_gap", halt, 0);
    tick(1);
    check("arb_halt_after_gap", halt, 1);
    ft_cs = 1'b1;
    tick(40);
    check("arb_session_done", halt, 0);

    // FT and CPU requests seen by IDLE on the same edge (CS given its synchronizer time)
    flash_byte = 8'h5A;
    cpu_addr   = 24'h000010;
    ft_cs      = 1'b0;
    tick(2);
    cpu_req = 1'b1;
    tick(1);
    check("sim_ft_wins", halt, 1);
    check("sim_busy_low", busy, 0);
    tick(20);
    check("sim_cpu_ignored", busy, 0);
    ft_cs = 1'b1;
    tick(18);
    check("sim_rel_busy", busy, 0);
    check("sim_rel_reset", cpu_rst, 1);
    tick(1);
    check("sim_rel_done", halt, 0);
    check("sim_no_accept_yet", busy, 0);
    tick(1);
    check("sim_cpu_accept", busy, 1);
    check("sim_cpu_out_of_reset", cpu_rst, 0);
    wait_valid(400, n);
    cpu_req = 1'b0;
    check("sim_latency", 1 + n, 161);
    check("sim_data", data, 8'h5A);
    tick(4);

    // Reset in the middle of an engine read
    flash_byte = 8'hFF;
    cpu_addr   = 24'h000100;
    cpu_req    = 1'b1;
    tick(1);
    cpu_req = 1'b0;
    tick(30);
    rst = 1'b1;
    tick(1);
    check("mrst_cs", spi_cs, 1);
    check("mrst_sck", spi_clk, 0);
    check("mrst_busy", busy, 0);
    check("mrst_halt", halt, 0);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (valid === 1'b1) seen = 1'b1;
    end
    check("mrst_no_valid", seen, 0);
    flash_byte = 8'h81;
    cpu_addr   = 24'h00ABCD;
    cpu_req    = 1'b1;
    wait_valid(400, n);
    cpu_req = 1'b0;
    check("mrst_new_latency", n, 161);
    check("mrst_new_data", data, 8'h81);
    check("mrst_new_mosi", cap[39:8], 32'h0300ABCD);
    tick(4);

    // CS pulse shorter than the settle window: FT_HALT straight to FT_RELEASE
    base        = cs_falls;
    use_tb_miso = 1'b1;
    tb_miso     = 1'b1;
    ft_cs       = 1'b0;
    tick(3);
    check("short_halt", halt, 1);
    ft_cs = 1'b1;
    tick(9);
    check("short_rel_halt", halt, 1);
    check("short_rel_cs", spi_cs, 1);
    check("short_ft_miso_undriven", (ft_miso === 1'b1), 0);
    tick(14);
    check("short_hold_end", halt, 1);
    tick(1);
    check("short_released", halt, 0);
    check("short_released_reset", cpu_rst, 0);
    check("short_cs_never_low", cs_falls - base, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_flash_arbiter.md
Name: spi_flash_arbiter

Overview:
- Sequences ownership of the board SPI flash between two requesters: the FT2232 programming port (raw pass-through) and an on-chip single-byte read engine serving 6809 boot/fetch requests.
- Owns the HALT/RESET handshake to the 6809: it halts and resets the CPU before handing the bus to the FT2232, and holds reset after the session ends.
- Sits between the FT2232/CPU side and the flash pins.

Parameters:
- CLK_DIV, 2: half-period of engine SCK in i_CLK cycles (>=1).
- HALT_SETTLE, 8: cycles HALT/RESET are held asserted before the FT2232 is granted the bus.
- RESET_HOLD, 16: cycles o_RESET stays asserted after the FT2232 releases CS.
- CS_GAP, 2: minimum cycles CS stays high after an engine transaction.

Ports:
- i_CLK  in  1  system clock
- i_RST  in  1  reset, synchronous, active-high
- i_FT_CS  in  1  FT2232 chip select, active-low, asynchronous
- i_FT_SCK  in  1  FT2232 SPI clock
- i_FT_MOSI  in  1  FT2232 data out
- o_FT_MISO  out  1  flash data to FT2232; high-Z unless granted
- i_CPU_REQ  in  1  read request, level
- i_CPU_ADDR  in  24  flash byte address
- o_CPU_BUSY  out  1  request accepted and not yet complete
- o_CPU_VALID  out  1  one-cycle pulse, o_CPU_DATA valid
- o_CPU_DATA  out  8  read byte, held until the next VALID
- i_SPI_MISO  in  1  flash data out
- o_SPI_CLK, o_SPI_MOSI, o_SPI_CS  out  1 each  flash pins
- o_HALT, o_RESET  out  1 each  6809 control, active-high

Behaviour:
- Reset values:
  - state IDLE
  - o_SPI_CS=1, o_SPI_CLK=0, o_SPI_MOSI=0, o_FT_MISO=Z
  - o_HALT=0, o_RESET=0
  - o_CPU_BUSY=0, o_CPU_VALID=0, o_CPU_DATA=0
  - all counters 0
- i_FT_CS passes through a 2-flop synchronizer. ft_req = ~synced CS.
- IDLE:
  - If ft_req, go to FT_HALT. FT has priority when both requesters are present.
  - Else if i_CPU_REQ, latch i_CPU_ADDR, set BUSY, and go to ENG_SHIFT.
- ENG_SHIFT:
  - CS=0. Shifts 40 bits MSB-first: 0x03, then ADDR[23:16], [15:8], [7:0], then 8 read bits. MOSI=0 during the read bits.
  - Mode 0 timing per bit: SCK low for CLK_DIV cycles with MOSI updated on entry to the low phase, then SCK high for CLK_DIV cycles. MISO is sampled on the cycle SCK rises.
  - After the last high phase: SCK=0, CS=1, VALID pulses, BUSY drops, DATA updates. Go to ENG_GAP.
- Latency from the accept cycle to VALID is 1 + 80*CLK_DIV cycles (161 at default).
- ENG_GAP: CS=1 for CS_GAP cycles, then IDLE.
- FT_HALT:
  - o_HALT=1, o_RESET=1, SPI CS=1.
  - Wait HALT_SETTLE cycles. If ft_req is still set, go to FT_PASS; otherwise go to FT_RELEASE.
- FT_PASS:
  - o_SPI_CLK=i_FT_SCK, o_SPI_MOSI=i_FT_MOSI, o_SPI_CS=i_FT_CS, o_FT_MISO=i_SPI_MISO. These are combinational, no added latency.
  - HALT=1, RESET=1.
  - When ft_req falls, go to FT_RELEASE.
- FT_RELEASE:
  - CS=1, SCK=0, FT_MISO=Z, HALT=1, RESET=1 for RESET_HOLD cycles. Then both drop and go to IDLE.
  - An FT CS reassertion here is served from IDLE afterwards.
- Host protocol: the FT2232 waits at least HALT_SETTLE+3 cycles after asserting CS before clocking SCK.
- Arbitration boundaries:
  - ft_req arriving during ENG_SHIFT/ENG_GAP does not abort. The engine completes, then IDLE grants FT.
  - i_CPU_REQ during FT states is ignored (BUSY=0). It is accepted from IDLE after release, at which point the 6809 is out of reset.
- Simultaneous ft_req and CPU_REQ in IDLE: FT wins.
- i_RST mid-operation: next edge returns everything to reset values (CS high, HALT/RESET low). No VALID is produced for the aborted read.
- i_CPU_ADDR changes after accept have no effect.

Test Plan:
- Reset, then i_CPU_REQ=1 with ADDR=0x012345 and the flash model returning 0xA5 -> MOSI stream 0x03,0x01,0x23,0x45. VALID 161 cycles after accept with DATA=0xA5. CS high for 2 cycles afterwards.
- i_FT_CS low from IDLE -> HALT/RESET rise 3 cycles later. After HALT_SETTLE, SPI pins track FT pins and FT_MISO follows SPI_MISO. After CS goes high: RESET held 16 more cycles, then HALT=RESET=0.
- i_FT_CS low 50 cycles into a CPU read -> read completes with correct VALID/DATA. HALT rises only after ENG_GAP.
- FT_CS and CPU_REQ asserted together in IDLE -> FT session first. CPU read accepted only after FT_RELEASE completes.
- i_RST pulse mid-ENG_SHIFT -> CS=1, SCK=0, BUSY=0 next cycle, no VALID. A new request afterwards completes normally.
- FT_CS pulse shorter than HALT_SETTLE -> goes FT_HALT to FT_RELEASE. SPI CS never goes low, FT_MISO stays Z.
